// File: rtl/mult_arb_pkg.sv
// Shared types and defaults for the mult_32 round-robin front end.
// Holds the FSM state encoding, default sizing constants and a counter-width helper.
package mult_arb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LAUNCH  = 3'd1,
        ST_WAIT    = 3'd2,
        ST_DELIVER = 3'd3,
        ST_ABORT   = 3'd4
    } state_t;

    localparam int W_DEF        = 16;
    localparam int INIT_CYC_DEF = 2;
    localparam int TIMEOUT_DEF  = 64;

    // Bits needed to hold values 0..value-1; never less than one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r++;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational rotating-priority picker: first set request at or after ptr, wrapping.
// Produces both the one-hot grant and the binary index of the winner.
module rr_arbiter
    import mult_arb_pkg::*;
#(
    parameter  int N  = 2,
    localparam int PW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  grant,
    output logic [PW-1:0] winner
);

    logic          found;
    logic [PW-1:0] idx;

    always_comb begin
        grant  = '0;
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 0; k < N; k++) begin
            idx = PW'((int'(ptr) + k) % N);
            if (!found && req[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// Round-robin scheduler sharing one mult_32 between N clients, with a WAIT watchdog.
// Latches the winner's operands, pulses init, waits for a fresh done edge, returns pp.
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int N        = 2,
    parameter int W        = W_DEF,
    parameter int INIT_CYC = INIT_CYC_DEF,
    parameter int TIMEOUT  = TIMEOUT_DEF
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] a_in,
    input  logic [N*W-1:0] b_in,
    output logic [N-1:0]   gnt,
    output logic [2*W-1:0] res,
    output logic [N-1:0]   res_valid,
    output logic [N-1:0]   err,
    output logic           busy,
    output logic           m_init,
    output logic [W-1:0]   m_A,
    output logic [W-1:0]   m_B,
    input  logic [2*W-1:0] m_pp,
    input  logic           m_done
);

    localparam int PW = clog2(N);
    localparam int LW = clog2(INIT_CYC + 1);
    localparam int TW = clog2(TIMEOUT + 1);

    state_t         state_reg;
    logic [PW-1:0]  ptr_reg;
    logic [N-1:0]   gnt_reg;
    logic [2*W-1:0] res_reg;
    logic [N-1:0]   res_valid_reg;
    logic [N-1:0]   err_reg;
    logic           m_init_reg;
    logic [W-1:0]   m_a_reg;
    logic [W-1:0]   m_b_reg;
    logic           done_q_reg;
    logic [LW-1:0]  launch_cnt_reg;
    logic [TW-1:0]  wd_cnt_reg;

    logic [W-1:0]   a_arr [N];
    logic [W-1:0]   b_arr [N];
    logic [N-1:0]   arb_grant;
    logic [PW-1:0]  arb_winner;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_unpack
            assign a_arr[gi] = a_in[gi*W +: W];
            assign b_arr[gi] = b_in[gi*W +: W];
        end
    endgenerate

    rr_arbiter #(.N(N)) u_rr (
        .req    (req),
        .ptr    (ptr_reg),
        .grant  (arb_grant),
        .winner (arb_winner)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            ptr_reg        <= '0;
            gnt_reg        <= '0;
            res_reg        <= '0;
            res_valid_reg  <= '0;
            err_reg        <= '0;
            m_init_reg     <= 1'b0;
            m_a_reg        <= '0;
            m_b_reg        <= '0;
            done_q_reg     <= 1'b0;
            launch_cnt_reg <= '0;
            wd_cnt_reg     <= '0;
        end else begin
            done_q_reg    <= m_done;
            res_valid_reg <= '0;
            err_reg       <= '0;
            case (state_reg)
                ST_IDLE: begin
                    if (|req) begin
                        gnt_reg        <= arb_grant;
                        m_a_reg        <= a_arr[arb_winner];
                        m_b_reg        <= b_arr[arb_winner];
                        ptr_reg        <= (int'(arb_winner) == N - 1) ? '0 : arb_winner + PW'(1);
                        m_init_reg     <= 1'b1;
                        launch_cnt_reg <= '0;
                        state_reg      <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: begin
                    if (int'(launch_cnt_reg) == INIT_CYC - 1) begin
                        m_init_reg <= 1'b0;
                        wd_cnt_reg <= '0;
                        state_reg  <= ST_WAIT;
                    end else begin
                        launch_cnt_reg <= launch_cnt_reg + LW'(1);
                    end
                end
                ST_WAIT: begin
                    // Only a 0->1 transition counts, so a done left high from the last op is ignored.
                    if (m_done && !done_q_reg) begin
                        res_reg       <= m_pp;
                        res_valid_reg <= gnt_reg;
                        state_reg     <= ST_DELIVER;
                    end else if (int'(wd_cnt_reg) == TIMEOUT - 1) begin
                        err_reg   <= gnt_reg;
                        state_reg <= ST_ABORT;
                    end else begin
                        wd_cnt_reg <= wd_cnt_reg + TW'(1);
                    end
                end
                ST_DELIVER, ST_ABORT: begin
                    gnt_reg   <= '0;
                    state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    assign gnt       = gnt_reg;
    assign res       = res_reg;
    assign res_valid = res_valid_reg;
    assign err       = err_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign m_init    = m_init_reg;
    assign m_A       = m_a_reg;
    assign m_B       = m_b_reg;

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter with a behavioural mult_32 stub (normal, stale-done, hung).
// Expected service order is derived from round-robin rules over each batch of requests.
module tb_mult_arbiter;

    localparam int N        = 2;
    localparam int W        = 16;
    localparam int INIT_CYC = 2;
    localparam int TIMEOUT  = 64;

    logic           clk  = 1'b0;
    logic           rst  = 1'b1;
    logic [N-1:0]   req  = '0;
    logic [N*W-1:0] a_in = '0;
    logic [N*W-1:0] b_in = '0;
    logic [N-1:0]   gnt;
    logic [2*W-1:0] res;
    logic [N-1:0]   res_valid;
    logic [N-1:0]   err;
    logic           busy;
    logic           m_init;
    logic [W-1:0]   m_A;
    logic [W-1:0]   m_B;
    logic [2*W-1:0] m_pp;
    logic           m_done;

    always #5 clk = ~clk;

    mult_arbiter #(.N(N), .W(W), .INIT_CYC(INIT_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .a_in      (a_in),
        .b_in      (b_in),
        .gnt       (gnt),
        .res       (res),
        .res_valid (res_valid),
        .err       (err),
        .busy      (busy),
        .m_init    (m_init),
        .m_A       (m_A),
        .m_B       (m_B),
        .m_pp      (m_pp),
        .m_done    (m_done)
    );

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // mult_32 stand-in. mode 0: done drops on init, rises with pp after a latency.
    // mode 1: done and old pp stay high through launch, dip once, then rise with new pp.
    // mode 2: done drops on init and never returns.
    int             stub_mode = 0;
    logic           stub_run;
    int             stub_cnt;
    logic [W-1:0]   sa, sb;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_done   <= 1'b0;
            m_pp     <= '0;
            stub_run <= 1'b0;
            stub_cnt <= 0;
            sa       <= '0;
            sb       <= '0;
        end else if (m_init) begin
            stub_run <= 1'b1;
            sa       <= m_A;
            sb       <= m_B;
            stub_cnt <= (stub_mode == 1) ? int'($urandom_range(3, 8)) : int'($urandom_range(2, 8));
            if (stub_mode != 1) m_done <= 1'b0;
        end else if (stub_run) begin
            if (stub_cnt == 0) begin
                stub_run <= 1'b0;
                if (stub_mode != 2) begin
                    m_pp   <= {16'h0, sa} * {16'h0, sb};
                    m_done <= 1'b1;
                end
            end else begin
                stub_cnt <= stub_cnt - 1;
                if (stub_mode == 1 && stub_cnt == 1) m_done <= 1'b0;
            end
        end
    end

    typedef struct {
        int             client;
        bit             is_err;
        logic [2*W-1:0] prod;
    } exp_t;

    exp_t           exp_q[$];
    logic [2*W-1:0] last_res = '0;
    int             init_run = 0;
    int             wait_t   = 0;
    bit             post_out = 1'b0;

    // Monitor: pops one expectation for every res_valid/err strobe.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                init_run = 0;
                wait_t   = 0;
                post_out = 1'b0;
                last_res = '0;
            end else begin
                if (post_out) begin
                    check("pulse_one_cycle", {res_valid, err}, 0);
                    check("busy_after_out", busy, 0);
                    post_out = 1'b0;
                end
                if (m_init) begin
                    init_run++;
                end else if (init_run != 0) begin
                    check("m_init_len", init_run, INIT_CYC);
                    init_run = 0;
                    wait_t   = 0;
                end else begin
                    wait_t++;
                end
                if (!$onehot0(gnt)) check("gnt_onehot", gnt, 0);
                if (res_valid != 0 || err != 0) begin
                    post_out = 1'b1;
                    if (exp_q.size() == 0) begin
                        check("unexpected_out", {res_valid, err}, 0);
                    end else begin
                        e = exp_q.pop_front();
                        if (e.is_err) begin
                            check("err_owner", err, 64'(1) << e.client);
                            check("err_no_valid", res_valid, 0);
                            check("res_held_on_err", res, last_res);
                            check("abort_time", wait_t, TIMEOUT);
                            $display("[TB] client %0d abort after %0d wait cycles", e.client, wait_t);
                        end else begin
                            check("valid_owner", res_valid, 64'(1) << e.client);
                            check("res_value", res, e.prod);
                            last_res = e.prod;
                            $display("[TB] client %0d result 0x%08h", e.client, res);
                        end
                    end
                end
            end
        end
    end

    int             ptr_m = 0;
    int             cnt [N];
    logic [W-1:0]   opa [N][4];
    logic [W-1:0]   opb [N][4];

    function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        return {{W{1'b0}}, a} * {{W{1'b0}}, b};
    endfunction

    // All clients with cnt>0 request together from IDLE; each keeps req high until its
    // last op is answered, presenting the next operands after each strobe.
    task automatic run_batch(input bit expect_err, input int budget);
        int   left [N];
        int   pos [N];
        int   c;
        int   n;
        int   first_c;
        bit   any;
        exp_t e;
        first_c = -1;
        for (int i = 0; i < N; i++) left[i] = cnt[i];
        any = 1'b1;
        while (any) begin
            any = 1'b0;
            for (int k = 0; k < N; k++) begin
                c = (ptr_m + k) % N;
                if (!any && left[c] > 0) begin
                    any      = 1'b1;
                    e.client = c;
                    e.is_err = expect_err;
                    e.prod   = ref_prod(opa[c][cnt[c]-left[c]], opb[c][cnt[c]-left[c]]);
                    exp_q.push_back(e);
                    if (first_c < 0) first_c = c;
                    left[c]--;
                    ptr_m = (c + 1) % N;
                end
            end
        end
        @(negedge clk);
        for (int i = 0; i < N; i++) begin
            pos[i] = 0;
            if (cnt[i] > 0) begin
                a_in[i*W +: W] = opa[i][0];
                b_in[i*W +: W] = opb[i][0];
                req[i] = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        check("grant_latency", gnt, 64'(1) << first_c);
        check("m_A_latched", m_A, opa[first_c][0]);
        check("m_B_latched", m_B, opb[first_c][0]);
        n = 0;
        do begin
            @(negedge clk);
            n++;
            for (int i = 0; i < N; i++) begin
                if (res_valid[i] || err[i]) begin
                    pos[i]++;
                    if (pos[i] < cnt[i]) begin
                        a_in[i*W +: W] = opa[i][pos[i]];
                        b_in[i*W +: W] = opb[i][pos[i]];
                    end else begin
                        req[i] = 1'b0;
                    end
                end
            end
        end while ((req != 0 || busy) && n < budget);
        check("batch_drained", exp_q.size(), 0);
        req = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        exp_q.delete();
    endtask

    initial begin
        int n;
        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_gnt", gnt, 0);
        check("rst_res", res, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_err", err, 0);
        check("rst_busy", busy, 0);
        check("rst_m_init", m_init, 0);
        check("rst_m_A", m_A, 0);
        check("rst_m_B", m_B, 0);
        @(negedge clk);
        rst = 1'b0;

        // Single op from client 0
        stub_mode = 0;
        cnt = '{1, 0};
        opa[0][0] = 16'h00F7;
        opb[0][0] = 16'h007F;
        run_batch(1'b0, 200);
        check("tp1_product", res, 32'h00007A89);

        // Both held continuously, client 0 twice: expect 0,1,0
        do_reset();
        cnt = '{2, 1};
        opa[0][0] = 16'd3;    opb[0][0] = 16'd5;
        opa[0][1] = 16'd3;    opb[0][1] = 16'd5;
        opa[1][0] = 16'hFFFF; opb[1][0] = 16'hFFFF;
        run_batch(1'b0, 300);
        check("tp2_last_product", res, 32'h0000000F);

        // done left high from the previous op must not deliver stale pp
        stub_mode = 1;
        cnt = '{1, 1};
        for (int i = 0; i < N; i++) begin
            opa[i][0] = 16'($urandom);
            opb[i][0] = 16'($urandom);
        end
        run_batch(1'b0, 300);

        // Hung multiplier: watchdog abort, then normal service resumes
        stub_mode = 2;
        cnt = '{1, 0};
        opa[0][0] = 16'h1234;
        opb[0][0] = 16'h0042;
        run_batch(1'b1, 300);
        stub_mode = 0;
        cnt = '{1, 0};
        opa[0][0] = 16'h0101;
        opb[0][0] = 16'h0202;
        run_batch(1'b0, 300);

        // Async reset during WAIT of a client 1 op
        stub_mode = 2;
        @(negedge clk);
        a_in[W +: W] = 16'hABCD;
        b_in[W +: W] = 16'h0003;
        req = 2'b10;
        repeat (INIT_CYC + 6) @(posedge clk);
        check("mid_wait_busy", busy, 1);
        #2;
        rst = 1'b1;
        #1;
        check("arst_gnt", gnt, 0);
        check("arst_res", res, 0);
        check("arst_res_valid", res_valid, 0);
        check("arst_err", err, 0);
        check("arst_busy", busy, 0);
        check("arst_m_init", m_init, 0);
        check("arst_m_A", m_A, 0);
        check("arst_m_B", m_B, 0);
        req = '0;
        exp_q.delete();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        ptr_m = 0;
        stub_mode = 0;
        cnt = '{0, 1};
        opa[1][0] = 16'hABCD;
        opb[1][0] = 16'h0003;
        run_batch(1'b0, 300);

        // Client 0 drops req and changes operands one cycle after grant
        @(negedge clk);
        a_in[0 +: W] = 16'h0F0F;
        b_in[0 +: W] = 16'h0011;
        req = 2'b01;
        begin
            exp_t e;
            e.client = 0;
            e.is_err = 1'b0;
            e.prod   = ref_prod(16'h0F0F, 16'h0011);
            exp_q.push_back(e);
        end
        ptr_m = 1;
        @(posedge clk);
        #1;
        check("drop_grant", gnt, 2'b01);
        @(negedge clk);
        req = '0;
        a_in[0 +: W] = 16'hFFFF;
        b_in[0 +: W] = 16'hFFFF;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((exp_q.size() != 0 || busy) && n < 200);
        check("drop_drained", exp_q.size(), 0);

        // Random batches
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                cnt[i] = int'($urandom_range(0, 2));
                for (int j = 0; j < 4; j++) begin
                    opa[i][j] = 16'($urandom);
                    opb[i][j] = 16'($urandom);
                end
            end
            if (cnt[0] == 0 && cnt[1] == 0) cnt[0] = 1;
            run_batch(1'b0, 600);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
